// File: rtl/param_ram.sv
// param_ram: byte-strobed single-port RAM that zero-fills itself after reset/clr,
// with a read pipeline of RD_LAT stages and out-of-range error reporting.
module param_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic              clr,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   init_addr, init_addr_nx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc, in_range;
    logic [DATA_W-1:0]   rd_word;
    logic                v [RD_LAT];
    logic [DATA_W-1:0]   d [RD_LAT];
    logic                e [RD_LAT];

    assign ready    = state == RUN;
    assign acc      = en & ready;
    assign in_range = {1'b0, addr} < DEPTH_X;
    assign rd_word  = in_range ? mem[addr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nx;
            init_addr <= init_addr_nx;
        end
    end

    always_comb begin
        state_nx     = (state == RUN) ? (clr ? INIT : RUN) : ((!clr && init_addr == LAST) ? RUN : INIT);
        init_addr_nx = (clr || state == RUN) ? '0 : init_addr + ADDR_W'(1);
    end

    // Storage is not reset: the INIT sweep zero-fills it after every reset or clr.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_addr] <= '0;
        else if (acc && wr && in_range)
            for (int b = 0; b < NB; b++)
                if (wstrb[b])
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end

    // Each stage only loads when its input is valid, so the last stage holds rdata between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v[i] <= 1'b0;
                d[i] <= '0;
                e[i] <= 1'b0;
            end
        end else begin
            v[0] <= acc & ~wr;
            if (acc && !wr) begin
                d[0] <= rd_word;
                e[0] <= ~in_range;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    e[i] <= e[i-1];
                end
            end
        end
    end

    assign rvalid = v[RD_LAT-1];
    assign rdata  = d[RD_LAT-1];
    assign rerr   = e[RD_LAT-1];
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: three param_ram configurations driven in lockstep and checked every cycle
// against an array/queue memory model, plus literal checks of the headline scenarios.
module tb_param_ram;
    localparam int N = 3;

    logic        clk, rstn, en, wr, clr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic        ready [N];
    logic        rvalid [N];
    logic        rerr [N];
    logic [15:0] rdata [N];

    param_ram u0 (.clk(clk), .rstn(rstn), .en(en), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
                  .clr(clr), .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .rerr(rerr[0]));
    param_ram #(.DEPTH(12), .RD_LAT(3)) u1 (.clk(clk), .rstn(rstn), .en(en), .wr(wr), .addr(addr),
                  .wdata(wdata), .wstrb(wstrb), .clr(clr), .ready(ready[1]), .rvalid(rvalid[1]),
                  .rdata(rdata[1]), .rerr(rerr[1]));
    param_ram #(.RD_LAT(2)) u2 (.clk(clk), .rstn(rstn), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
                  .wstrb(wstrb), .clr(clr), .ready(ready[2]), .rvalid(rvalid[2]), .rdata(rdata[2]),
                  .rerr(rerr[2]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int dep(int g);
        return g == 1 ? 12 : 16;
    endfunction

    function automatic int lat(int g);
        return g == 0 ? 1 : (g == 1 ? 3 : 2);
    endfunction

    typedef struct {int due; logic [15:0] d; logic e;} rsp_t;
    typedef struct {int cyc; logic [15:0] d; logic e;} rec_t;

    int          total, bad, E;
    int          ileft [N];
    int          lo [N];
    logic [15:0] mem [N][16];
    logic [15:0] last [N];
    rsp_t        q [N][$];
    rec_t        lg [N][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Model: E counts clock edges; a read accepted at edge k is due in cycle k+RD_LAT-1.
    initial begin
        E = 0;
        for (int g = 0; g < N; g++) begin
            ileft[g] = dep(g);
            for (int a = 0; a < 16; a++) mem[g][a] = '0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int g = 0; g < N; g++) begin
                    q[g].delete();
                    ileft[g] = dep(g);
                    for (int a = 0; a < 16; a++) mem[g][a] = '0;
                end
            end else begin
                E++;
                for (int g = 0; g < N; g++) begin
                    while (q[g].size() > 0 && q[g][0].due < E) void'(q[g].pop_front());
                    if (ileft[g] == 0) begin
                        if (en && !wr) begin
                            rsp_t r;
                            r.due = E + lat(g) - 1;
                            r.d   = int'(addr) < dep(g) ? mem[g][addr] : 16'h0;
                            r.e   = int'(addr) >= dep(g);
                            q[g].push_back(r);
                        end
                        if (en && wr && int'(addr) < dep(g))
                            for (int b = 0; b < 2; b++)
                                if (wstrb[b]) mem[g][addr][8*b +: 8] = wdata[8*b +: 8];
                        if (clr) begin
                            ileft[g] = dep(g);
                            for (int a = 0; a < 16; a++) mem[g][a] = '0;
                        end
                    end else begin
                        ileft[g] = clr ? dep(g) : ileft[g] - 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        bit hit;
        for (int g = 0; g < N; g++) last[g] = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                if (!rstn) begin
                    chk($sformatf("rst_ready%0d", g), 32'(ready[g]), 0);
                    chk($sformatf("rst_rvalid%0d", g), 32'(rvalid[g]), 0);
                    chk($sformatf("rst_rdata%0d", g), 32'(rdata[g]), 0);
                    chk($sformatf("rst_rerr%0d", g), 32'(rerr[g]), 0);
                    last[g] = '0;
                end else begin
                    hit = q[g].size() > 0 && q[g][0].due == E;
                    chk($sformatf("ready%0d", g), 32'(ready[g]), 32'(ileft[g] == 0));
                    chk($sformatf("rvalid%0d", g), 32'(rvalid[g]), 32'(hit));
                    if (hit) begin
                        chk($sformatf("rdata%0d", g), 32'(rdata[g]), 32'(q[g][0].d));
                        chk($sformatf("rerr%0d", g), 32'(rerr[g]), 32'(q[g][0].e));
                        last[g] = q[g][0].d;
                    end else begin
                        chk($sformatf("rdata_hold%0d", g), 32'(rdata[g]), 32'(last[g]));
                    end
                    if (rvalid[g]) begin
                        rec_t r;
                        r.cyc = E;
                        r.d   = rdata[g];
                        r.e   = rerr[g];
                        lg[g].push_back(r);
                    end
                end
            end
        end
    end

    task automatic op(input logic e_, input logic w_, input logic [3:0] a_, input logic [15:0] d_,
                      input logic [1:0] s_, input logic c_);
        @(posedge clk);
        #1;
        en = e_; wr = w_; addr = a_; wdata = d_; wstrb = s_; clr = c_;
    endtask

    task automatic idle(input int n);
        repeat (n) op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic count_low(input int n);
        for (int g = 0; g < N; g++) lo[g] = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int g = 0; g < N; g++) if (!ready[g]) lo[g]++;
        end
    endtask

    initial begin
        int n0, n1, n2, rc;
        rstn = 0; en = 0; wr = 0; clr = 0; addr = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        count_low(24);
        chk("init_len0", lo[0], 16);
        chk("init_len1", lo[1], 12);
        chk("init_len2", lo[2], 16);

        for (int a = 0; a < 16; a++) op(1, 0, 4'(a), 0, 0, 0);
        idle(6);

        op(1, 1, 3, 16'hABCD, 2'b11, 0);
        op(1, 1, 3, 16'h1200, 2'b10, 0);
        n0 = lg[0].size();
        op(1, 0, 3, 0, 0, 0);
        idle(6);
        chk("strobe_cnt", lg[0].size() - n0, 1);
        if (lg[0].size() > n0) chk("strobe_data", 32'(lg[0][n0].d), 32'h12CD);

        for (int k = 0; k < 4; k++) op(1, 1, 4'(k), 16'(16'h1000 + k), 2'b11, 0);
        n1 = lg[1].size();
        op(1, 0, 0, 0, 0, 0);
        rc = E;
        for (int k = 1; k < 4; k++) op(1, 0, 4'(k), 0, 0, 0);
        idle(8);
        chk("lat_cnt", lg[1].size() - n1, 4);
        if (lg[1].size() >= n1 + 4)
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("lat_cyc%0d", k), lg[1][n1+k].cyc - rc, 3 + k);
                chk($sformatf("lat_data%0d", k), 32'(lg[1][n1+k].d), 32'h1000 + k);
            end

        op(1, 1, 13, 16'hFFFF, 2'b11, 0);
        n0 = lg[0].size();
        n1 = lg[1].size();
        op(1, 0, 13, 0, 0, 0);
        op(1, 0, 11, 0, 0, 0);
        idle(8);
        chk("oor_cnt", lg[1].size() - n1, 2);
        if (lg[1].size() >= n1 + 2) begin
            chk("oor_data", 32'(lg[1][n1].d), 0);
            chk("oor_err", 32'(lg[1][n1].e), 1);
            chk("inr_data", 32'(lg[1][n1+1].d), 0);
            chk("inr_err", 32'(lg[1][n1+1].e), 0);
        end
        if (lg[0].size() > n0) chk("wide_data", 32'(lg[0][n0].d), 32'hFFFF);

        op(1, 1, 5, 16'h5555, 2'b11, 0);
        n0 = lg[0].size();
        op(1, 0, 5, 0, 0, 1);
        @(posedge clk);
        #1 en = 0; clr = 0;
        count_low(24);
        chk("clr_len0", lo[0], 16);
        chk("clr_len1", lo[1], 12);
        if (lg[0].size() > n0) chk("clr_pre", 32'(lg[0][n0].d), 32'h5555);
        else chk("clr_pre_cnt", lg[0].size() - n0, 1);
        n0 = lg[0].size();
        op(1, 0, 5, 0, 0, 0);
        idle(6);
        if (lg[0].size() > n0) chk("clr_post", 32'(lg[0][n0].d), 0);
        else chk("clr_post_cnt", lg[0].size() - n0, 1);

        op(1, 1, 7, 16'h7777, 2'b11, 0);
        op(1, 0, 7, 0, 0, 0);
        idle(4);
        chk("pre_rst_rdata2", 32'(rdata[2]), 32'h7777);
        n2 = lg[2].size();
        op(1, 0, 7, 0, 0, 0);
        @(posedge clk);
        #1 rstn = 0; en = 0;
        #1;
        chk("rst_imm_rdata2", 32'(rdata[2]), 0);
        chk("rst_imm_rvalid2", 32'(rvalid[2]), 0);
        chk("rst_imm_ready2", 32'(ready[2]), 0);
        repeat (4) @(posedge clk);
        chk("rst_flush", lg[2].size() - n2, 0);
        #1 rstn = 1;
        count_low(24);
        chk("rst_init2", lo[2], 16);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                @(posedge clk);
                #1 rstn = 0; en = 0;
                repeat (2) @(posedge clk);
                #1 rstn = 1;
            end
            op(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 16'($urandom),
               2'($urandom), 1'($urandom_range(0, 49) == 0));
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
